uart_rx_param: RTL and testbench

Parametrised UART receiver for the UART command path. It replaces the fixed 8N1 receiver.
- Configurable baud, data width, parity and stop bits.
- 16x oversampling with 3-sample majority vote.
- Per-frame parity, framing and break detection.
- Ready/valid output holding register with overrun reporting.
Sits between the board rx pin and the command FIFO/decoder.

---
 rtl/uart_rx_param_if.sv | 32 +++
 rtl/uart_rx_param.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_param_if
// Purpose: Receive-side bus of the parametrised UART receiver. Carries the
//          ready/valid payload handshake plus the per-frame error flags and
//          the one-clock event pulses.
// Ports  : master - receiver side (drives data, valid, flags, pulses)
//          slave  - consumer side (drives rx_ready)
// Rev    : 1.0  initial release
// ============================================================================
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, break_det, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, break_det, overrun,
    output rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_param
// Purpose: Parametrised UART receiver. 16x oversampling with a 3-sample
//          majority vote, optional even/odd parity, 1 or 2 checked stop
//          bits, break detection and a ready/valid holding register with
//          overrun reporting.
// Ports  : clk    - system clock
//          rst    - asynchronous active-high reset
//          rx     - serial line (idle high, asynchronous to clk)
//          busy   - high whenever the receiver FSM is not idle
//          rx_bus - receive bus (uart_rx_param_if.master)
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_param #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int OS_DIV    = CLK_FREQ / (BAUD * 16)
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              rx,
  output logic             busy,
  uart_rx_param_if.master  rx_bus
);

  localparam int               DIV_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(OS_DIV - 1);
  localparam logic [3:0]       BIT_LAST   = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic             HAS_PARITY = (PARITY != 0);
  localparam logic             ODD_PARITY = (PARITY == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic                 rx_meta, rx_sync, rx_prev;
  logic [2:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           os_cnt;
  logic [1:0]           samp;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 par_err;
  logic                 frame_err;
  logic                 stop_cnt;
  logic                 first_stop;

  logic start_det, tick, strobe, maj, frame_done, first_stop_v;
  logic is_break, par_err_v, accept;

  // Synchroniser preset to idle-high so reset release never looks like a
  // falling edge; rx_prev provides the edge detector's history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_det = (state == S_IDLE) && rx_prev && !rx_sync;
  // Ticks only matter while a frame is being timed.
  assign tick      = (state != S_IDLE) && (state != S_WAIT) && (div_cnt == DIV_LAST);
  // Ticks are numbered 1..16 within a bit; os_cnt holds the count already
  // seen, so os_cnt == 8 on a tick is the 9th tick, the decision point.
  assign strobe    = tick && (os_cnt == 4'd8);
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
  assign frame_done   = strobe && (state == S_STOP) && (stop_cnt == STOP_LAST);
  assign first_stop_v = (stop_cnt == 1'b0) ? maj : first_stop;
  assign is_break     = (shift_reg == '0) && (!HAS_PARITY || !par_bit) && !first_stop_v;
  assign par_err_v    = ((^shift_reg) ^ maj) != ODD_PARITY;
  assign accept       = rx_bus.rx_valid & rx_bus.rx_ready;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (start_det || state == S_IDLE || state == S_WAIT || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      os_cnt     <= '0;
      samp       <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
      stop_cnt   <= 1'b0;
      first_stop <= 1'b0;
    end else if (start_det) begin
      state     <= S_START;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else if (tick) begin
      os_cnt <= os_cnt + 1'b1;
      if (os_cnt == 4'd6) samp[0] <= rx_sync;
      if (os_cnt == 4'd7) samp[1] <= rx_sync;
      if (os_cnt == 4'd8) begin
        case (state)
          S_START: state <= maj ? S_IDLE : S_DATA;
          S_DATA: begin
            shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= HAS_PARITY ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            par_bit <= maj;
            par_err <= par_err_v;
            state   <= S_STOP;
          end
          S_STOP: begin
            if (!maj) frame_err <= 1'b1;
            if (stop_cnt == 1'b0) first_stop <= maj;
            stop_cnt <= stop_cnt + 1'b1;
            if (stop_cnt == STOP_LAST) state <= is_break ? S_WAIT : S_IDLE;
          end
          default: state <= state;
        endcase
      end
    end else if (state == S_WAIT && rx_sync) begin
      state <= S_IDLE;
    end
  end

  // Holding register: an accept on the completion clock frees the slot
  // first, so the new frame loads instead of being reported as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_bus.rx_data       <= '0;
      rx_bus.rx_valid      <= 1'b0;
      rx_bus.rx_parity_err <= 1'b0;
      rx_bus.rx_frame_err  <= 1'b0;
      rx_bus.break_det     <= 1'b0;
      rx_bus.overrun       <= 1'b0;
    end else begin
      rx_bus.break_det <= frame_done && is_break;
      rx_bus.overrun   <= frame_done && !is_break && rx_bus.rx_valid && !accept;
      if (frame_done && !is_break && (!rx_bus.rx_valid || accept)) begin
        rx_bus.rx_data       <= shift_reg;
        rx_bus.rx_valid      <= 1'b1;
        rx_bus.rx_parity_err <= par_err;
        rx_bus.rx_frame_err  <= frame_err | ~maj;
      end else if (accept) begin
        rx_bus.rx_valid      <= 1'b0;
        rx_bus.rx_parity_err <= 1'b0;
        rx_bus.rx_frame_err  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_param
// Purpose: Self-checking bench for uart_rx_param. Three instances: default
//          parameters (exact latency, glitch), fast 8N1 (handshake, overrun,
//          break, reset abort) and fast 7E2 (parity/framing table + random).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;

  localparam int DEF_BIT  = 864;  // 54 clocks/tick * 16
  localparam int FAST_BIT = 64;   // 4 clocks/tick * 16

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_def = 1'b1, rx_fast = 1'b1, rx_par = 1'b1;
  logic ready_def = 1'b1, ready_fast = 1'b1, ready_par = 1'b1;
  logic busy_def, busy_fast, busy_par;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param_if #(.DATA_BITS(8)) if_def ();
  uart_rx_param_if #(.DATA_BITS(8)) if_fast ();
  uart_rx_param_if #(.DATA_BITS(7)) if_par ();

  assign if_def.rx_ready  = ready_def;
  assign if_fast.rx_ready = ready_fast;
  assign if_par.rx_ready  = ready_par;

  uart_rx_param dut_def (
    .clk(clk), .rst(rst), .rx(rx_def), .busy(busy_def), .rx_bus(if_def)
  );
  uart_rx_param #(.CLK_FREQ(7_372_800), .BAUD(115200)) dut_fast (
    .clk(clk), .rst(rst), .rx(rx_fast), .busy(busy_fast), .rx_bus(if_fast)
  );
  uart_rx_param #(.CLK_FREQ(7_372_800), .BAUD(115200), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2)) dut_par (
    .clk(clk), .rst(rst), .rx(rx_par), .busy(busy_par), .rx_bus(if_par)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } beat_t;

  beat_t q_def[$], q_fast[$], q_par[$];
  int brk_def = 0, brk_fast = 0, brk_par = 0;
  int ovr_def = 0, ovr_fast = 0, ovr_par = 0;
  int def_rise = -1;

  // Accepted beats are logged on the falling edge before the accepting edge.
  always @(negedge clk) begin
    if (if_def.rx_valid && ready_def)
      q_def.push_back({9'(if_def.rx_data), if_def.rx_parity_err, if_def.rx_frame_err});
    if (if_fast.rx_valid && ready_fast)
      q_fast.push_back({9'(if_fast.rx_data), if_fast.rx_parity_err, if_fast.rx_frame_err});
    if (if_par.rx_valid && ready_par)
      q_par.push_back({9'(if_par.rx_data), if_par.rx_parity_err, if_par.rx_frame_err});
    if (if_def.break_det)  brk_def++;
    if (if_fast.break_det) brk_fast++;
    if (if_par.break_det)  brk_par++;
    if (if_def.overrun)  ovr_def++;
    if (if_fast.overrun) ovr_fast++;
    if (if_par.overrun)  ovr_par++;
    if (if_def.rx_valid && def_rise < 0) def_rise = cyc;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0:       rx_def  = v;
      1:       rx_fast = v;
      default: rx_par  = v;
    endcase
  endtask

  task automatic send_frame(input int which, input int bitclk, input int dbits,
                            input logic [8:0] data, input bit has_par, input logic pbit,
                            input int nstop, input logic [1:0] stops);
    drive(which, 1'b0);
    wait_clks(bitclk);
    for (int i = 0; i < dbits; i++) begin
      drive(which, data[i]);
      wait_clks(bitclk);
    end
    if (has_par) begin
      drive(which, pbit);
      wait_clks(bitclk);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(which, stops[i]);
      wait_clks(bitclk);
    end
    drive(which, 1'b1);
  endtask

  // Reference model: what a frame should produce, from line-level rules.
  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    bit         brk;
  } exp_t;

  function automatic exp_t model(input int dbits, input int pmode, input int nstop,
                                 input logic [8:0] data, input logic pbit,
                                 input logic [1:0] stops);
    exp_t e;
    logic [8:0] d;
    int ones;
    d = data & 9'((1 << dbits) - 1);
    ones = $countones(d) + ((pmode != 0) ? int'(pbit) : 0);
    e.data = d;
    e.brk  = (d == 0) && (pmode == 0 || pbit == 1'b0) && (stops[0] == 1'b0);
    e.perr = (pmode != 0) && ((ones % 2) != ((pmode == 2) ? 1 : 0));
    e.ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    return e;
  endfunction

  typedef struct {
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    logic [8:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    bit         e_brk;
  } vec_t;

  // Applies one 7E2 frame on dut_par and compares the outcome.
  task automatic run_par(input string tag, input logic [8:0] data, input logic pbit,
                         input logic [1:0] stops, input logic [8:0] e_data,
                         input logic e_perr, input logic e_ferr, input bit e_brk);
    int q0, b0;
    q0 = q_par.size();
    b0 = brk_par;
    send_frame(2, FAST_BIT, 7, data, 1'b1, pbit, 2, stops);
    wait_clks(2 * FAST_BIT);
    check({tag, " break"}, brk_par - b0, e_brk ? 1 : 0);
    check({tag, " beats"}, q_par.size() - q0, e_brk ? 0 : 1);
    if (!e_brk && q_par.size() > q0) begin
      check({tag, " data"}, q_par[q0].data, e_data);
      check({tag, " perr"}, q_par[q0].perr, e_perr);
      check({tag, " ferr"}, q_par[q0].ferr, e_ferr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int c0, q0, b0, o0;
    logic [8:0] rd;
    logic rp;
    logic [1:0] rs;
    exp_t e;

    vecs[0] = '{9'h55, 1'b1, 2'b11, 9'h55, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{9'h55, 1'b0, 2'b10, 9'h55, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{9'h2A, 1'b1, 2'b11, 9'h2A, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{9'h00, 1'b0, 2'b10, 9'h00, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{9'h00, 1'b0, 2'b01, 9'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{9'h7F, 1'b1, 2'b11, 9'h7F, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{9'h00, 1'b1, 2'b10, 9'h00, 1'b1, 1'b1, 1'b0};

    // Reset state
    wait_clks(5);
    check("reset def valid", if_def.rx_valid, 0);
    check("reset def data", if_def.rx_data, 0);
    check("reset def busy", busy_def, 0);
    check("reset fast flags", {if_fast.rx_parity_err, if_fast.rx_frame_err,
                               if_fast.break_det, if_fast.overrun}, 0);
    check("reset par data", if_par.rx_data, 0);
    rst = 1'b0;
    wait_clks(5);

    // Defaults: 'r' with exact completion latency (2 sync flops + edge
    // detect = 3 clocks, then the 9th tick of the 10th bit, then 1 clock).
    c0 = cyc;
    q0 = q_def.size();
    send_frame(0, DEF_BIT, 8, 9'h72, 1'b0, 1'b0, 1, 2'b11);
    wait_clks(100);
    check("def latency", def_rise, c0 + 3 + 54 * (16 * 9 + 9) + 1 - 1);
    check("def beats", q_def.size() - q0, 1);
    if (q_def.size() > q0) begin
      check("def data", q_def[q0].data, 9'h72);
      check("def flags", {q_def[q0].perr, q_def[q0].ferr}, 0);
    end

    // 200-clock glitch on the start bit
    q0 = q_def.size();
    rx_def = 1'b0;
    wait_clks(200);
    rx_def = 1'b1;
    check("glitch busy mid", busy_def, 1);
    wait_clks(800);
    check("glitch beats", q_def.size() - q0, 0);
    check("glitch busy end", busy_def, 0);

    // Back-to-back 'c','m','p' with zero idle
    q0 = q_fast.size();
    send_frame(1, FAST_BIT, 8, 9'h63, 1'b0, 1'b0, 1, 2'b11);
    send_frame(1, FAST_BIT, 8, 9'h6D, 1'b0, 1'b0, 1, 2'b11);
    send_frame(1, FAST_BIT, 8, 9'h70, 1'b0, 1'b0, 1, 2'b11);
    wait_clks(2 * FAST_BIT);
    check("b2b beats", q_fast.size() - q0, 3);
    if (q_fast.size() >= q0 + 3) begin
      check("b2b c", q_fast[q0].data, 9'h63);
      check("b2b m", q_fast[q0+1].data, 9'h6D);
      check("b2b p", q_fast[q0+2].data, 9'h70);
    end

    // Overrun while the consumer stalls
    ready_fast = 1'b0;
    q0 = q_fast.size();
    o0 = ovr_fast;
    send_frame(1, FAST_BIT, 8, 9'h6D, 1'b0, 1'b0, 1, 2'b11);
    wait_clks(32);
    send_frame(1, FAST_BIT, 8, 9'h70, 1'b0, 1'b0, 1, 2'b11);
    wait_clks(2 * FAST_BIT);
    check("ovr count", ovr_fast - o0, 1);
    check("ovr held valid", if_fast.rx_valid, 1);
    check("ovr held data", if_fast.rx_data, 9'h6D);
    ready_fast = 1'b1;
    wait_clks(3);
    check("ovr cleared", if_fast.rx_valid, 0);
    check("ovr beats", q_fast.size() - q0, 1);
    if (q_fast.size() > q0) check("ovr beat data", q_fast[q0].data, 9'h6D);

    // Break: line low for 3 frame times, then a normal frame
    q0 = q_fast.size();
    b0 = brk_fast;
    rx_fast = 1'b0;
    wait_clks(3 * 10 * FAST_BIT);
    rx_fast = 1'b1;
    wait_clks(2 * FAST_BIT);
    check("break count", brk_fast - b0, 1);
    check("break beats", q_fast.size() - q0, 0);
    send_frame(1, FAST_BIT, 8, 9'h41, 1'b0, 1'b0, 1, 2'b11);
    wait_clks(2 * FAST_BIT);
    check("post-break beats", q_fast.size() - q0, 1);
    if (q_fast.size() > q0) check("post-break data", q_fast[q0].data, 9'h41);

    // Reset in the middle of a data bit, then a clean frame
    q0 = q_fast.size();
    rx_fast = 1'b0;
    wait_clks(FAST_BIT + FAST_BIT + FAST_BIT / 2);
    rst = 1'b1;
    rx_fast = 1'b1;
    wait_clks(3);
    check("rst busy", busy_fast, 0);
    rst = 1'b0;
    wait_clks(2 * FAST_BIT);
    send_frame(1, FAST_BIT, 8, 9'h72, 1'b0, 1'b0, 1, 2'b11);
    wait_clks(2 * FAST_BIT);
    check("rst beats", q_fast.size() - q0, 1);
    if (q_fast.size() > q0) check("rst data", q_fast[q0].data, 9'h72);

    // 7E2 table
    for (int i = 0; i < 7; i++) begin
      run_par($sformatf("vec%0d", i), vecs[i].data, vecs[i].pbit, vecs[i].stops,
              vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_brk);
    end

    // 7E2 random frames against the model
    for (int i = 0; i < 8; i++) begin
      rd = 9'($urandom_range(0, 127));
      rp = 1'($urandom_range(0, 1));
      rs = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      e  = model(7, 1, 2, rd, rp, rs);
      run_par($sformatf("rnd%0d", i), rd, rp, rs, e.data, e.perr, e.ferr, e.brk);
      wait_clks($urandom_range(0, 20));
    end

    check("par no overrun", ovr_par, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
